// File: rtl/list_fold_if.sv
`default_nettype none
// ============================================================================
// Module   : list_fold_if
// Purpose  : Upstream list handshake plus downstream result handshake for list_fold.
// Revision : 1.0
// ============================================================================
interface list_fold_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) ();
  logic                 src_ready;
  logic                 src_req;
  logic                 src_ack;
  logic                 src_eol;
  logic [WIDTH-1:0]     src_value;
  logic [ACC_WIDTH-1:0] result;
  logic [ACC_WIDTH-1:0] count;
  logic                 overflow;
  logic                 result_valid;
  logic                 result_ack;

  // Fold engine side
  modport master (
    output src_ready, src_req, result, count, overflow, result_valid,
    input  src_ack, src_eol, src_value, result_ack
  );

  // Upstream enumerator / downstream consumer side
  modport slave (
    input  src_ready, src_req, result, count, overflow, result_valid,
    output src_ack, src_eol, src_value, result_ack
  );
endinterface
`default_nettype wire

// File: rtl/list_fold.sv
`default_nettype none
// ============================================================================
// Module   : list_fold
// Purpose  : Folds one upstream list into sum/max/min/count; optional sum
//            saturation enabled by macro LIST_FOLD_SAT_EN.
// Revision : 1.0
// ============================================================================
module list_fold #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  wire logic       clock,
  input  wire logic       reset_n,
  input  wire logic       start,
  input  wire logic [1:0] op,
  input  wire logic       abort,
  list_fold_if.master     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] c_op_sum = 2'b00;
  localparam logic [1:0] c_op_max = 2'b01;
  localparam logic [1:0] c_op_min = 2'b10;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_count;
  logic [ACC_WIDTH-1:0] w_val_ext;
  logic [ACC_WIDTH:0]   w_sum;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_consume;
  logic                 w_launch;

  assign w_launch  = (r_state == S_IDLE) && start;
  // abort takes priority over an element arriving in the same cycle
  assign w_consume = (r_state == S_RUN) && bus.src_ack && !abort;
  assign w_sum     = {1'b0, r_acc} + {1'b0, w_val_ext};

  always_comb begin
    w_val_ext              = '0;
    w_val_ext[WIDTH-1:0]   = bus.src_value;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_START;
      S_START: w_next = abort ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                            w_next = S_IDLE;
        else if (bus.src_ack && bus.src_eol)  w_next = S_DONE;
      end
      S_DONE:  if (bus.result_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef LIST_FOLD_SAT_EN
  logic r_ovf;
  logic w_ovf_next;
`endif

  always_comb begin
    w_acc_next = r_acc;
`ifdef LIST_FOLD_SAT_EN
    w_ovf_next = r_ovf;
`endif
    case (r_op)
      c_op_sum: begin
`ifdef LIST_FOLD_SAT_EN
        if (w_sum[ACC_WIDTH]) begin
          w_acc_next = '1;
          w_ovf_next = 1'b1;
        end else begin
          w_acc_next = w_sum[ACC_WIDTH-1:0];
        end
`else
        w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif
      end
      // first element seeds max/min regardless of its value
      c_op_max: if (r_count == '0 || w_val_ext > r_acc) w_acc_next = w_val_ext;
      c_op_min: if (r_count == '0 || w_val_ext < r_acc) w_acc_next = w_val_ext;
      default:  w_acc_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= 2'b00;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_launch) begin
      r_op    <= op;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_consume) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 1'b1;
    end
  end

`ifdef LIST_FOLD_SAT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       r_ovf <= 1'b0;
    else if (w_launch)  r_ovf <= 1'b0;
    else if (w_consume) r_ovf <= w_ovf_next;
  end
  assign bus.overflow = r_ovf;
`else
  assign bus.overflow = 1'b0;
`endif

  assign bus.src_ready    = (r_state == S_START) || (r_state == S_RUN);
  assign bus.src_req      = (r_state == S_RUN);
  assign bus.result_valid = (r_state == S_DONE);
  assign bus.result       = r_acc;
  assign bus.count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_list_fold.sv
`default_nettype none
// ============================================================================
// Module   : tb_list_fold
// Purpose  : Directed self-checking bench for list_fold (ACC_WIDTH = 8).
// Revision : 1.0
// ============================================================================
module tb_list_fold;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [1:0] op;
  logic       abort;
  int         n_tests;
  int         n_fail;
  int         vals [0:7];

  list_fold_if #(.WIDTH(8), .ACC_WIDTH(8)) bus ();

  list_fold #(.WIDTH(8), .ACC_WIDTH(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .abort   (abort),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts from IDLE; feeds vals[0..n-1], asserting abort with element abort_idx.
  task automatic fold(input logic [1:0] o, input int n, input int abort_idx);
    start = 1'b1;
    op    = o;
    tick();
    start = 1'b0;
    check("start_ready", bus.src_ready, 1);
    check("start_req", bus.src_req, 0);
    tick();
    check("run_req", bus.src_req, 1);
    for (int i = 0; i < n; i++) begin
      bus.src_ack   = 1'b1;
      bus.src_value = vals[i][7:0];
      bus.src_eol   = (i == n - 1);
      abort         = (i == abort_idx);
      check("rv_low_in_run", bus.result_valid, 0);
      tick();
      bus.src_ack = 1'b0;
      bus.src_eol = 1'b0;
      abort       = 1'b0;
      if (i == abort_idx) break;
    end
  endtask

  task automatic ack_result();
    bus.result_ack = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    check("rv_after_ack", bus.result_valid, 0);
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset_n        = 1'b0;
    start          = 1'b0;
    op             = 2'b00;
    abort          = 1'b0;
    bus.src_ack    = 1'b0;
    bus.src_eol    = 1'b0;
    bus.src_value  = '0;
    bus.result_ack = 1'b0;
    #12;
    check("rst_ready", bus.src_ready, 0);
    check("rst_req", bus.src_req, 0);
    check("rst_rv", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_count", bus.count, 0);
    check("rst_ovf", bus.overflow, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Sum 3..7
    vals = '{3, 4, 5, 6, 7, 0, 0, 0};
    fold(2'b00, 5, -1);
    check("sum_rv", bus.result_valid, 1);
    check("sum_result", bus.result, 25);
    check("sum_count", bus.count, 5);
    check("sum_ready_off", bus.src_ready, 0);
    check("sum_req_off", bus.src_req, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done_abort_ignored", bus.result_valid, 1);
    check("done_hold", bus.result, 25);
    ack_result();

    // Max and min of 5,9,2
    vals = '{5, 9, 2, 0, 0, 0, 0, 0};
    fold(2'b01, 3, -1);
    check("max_result", bus.result, 9);
    check("max_count", bus.count, 3);
    ack_result();
    fold(2'b10, 3, -1);
    check("min_result", bus.result, 2);
    check("min_count", bus.count, 3);
    ack_result();

    // Count-only leaves acc at zero
    vals = '{3, 4, 5, 6, 7, 0, 0, 0};
    fold(2'b11, 5, -1);
    check("cnt_result", bus.result, 0);
    check("cnt_count", bus.count, 5);
    ack_result();

    // Sum overflow: 200 + 100 = 300
    vals = '{200, 100, 0, 0, 0, 0, 0, 0};
    fold(2'b00, 2, -1);
`ifdef LIST_FOLD_SAT_EN
    check("ovf_result", bus.result, 255);
    check("ovf_flag", bus.overflow, 1);
`else
    check("ovf_result", bus.result, 44);
    check("ovf_flag", bus.overflow, 0);
`endif
    ack_result();

    // Abort with the second element's ack
    vals = '{1, 2, 3, 4, 0, 0, 0, 0};
    fold(2'b00, 4, 1);
    check("abort_ready", bus.src_ready, 0);
    check("abort_req", bus.src_req, 0);
    check("abort_rv", bus.result_valid, 0);
    tick();
    check("abort_rv_later", bus.result_valid, 0);
    check("abort_idle", bus.src_ready, 0);
    vals = '{3, 4, 5, 6, 7, 0, 0, 0};
    fold(2'b00, 5, -1);
    check("post_abort_result", bus.result, 25);
    check("post_abort_count", bus.count, 5);
    ack_result();

    // eol without ack is ignored; start in RUN is ignored
    start = 1'b1;
    op    = 2'b00;
    tick();
    start = 1'b0;
    tick();
    bus.src_eol = 1'b1;
    start       = 1'b1;
    tick();
    bus.src_eol = 1'b0;
    start       = 1'b0;
    check("eol_noack_req", bus.src_req, 1);
    check("eol_noack_rv", bus.result_valid, 0);
    bus.src_ack   = 1'b1;
    bus.src_eol   = 1'b1;
    bus.src_value = 8'd10;
    tick();
    bus.src_ack = 1'b0;
    bus.src_eol = 1'b0;
    check("eol_noack_result", bus.result, 10);
    check("eol_noack_count", bus.count, 1);

    // result_ack and start together: start dropped
    bus.result_ack = 1'b1;
    start          = 1'b1;
    tick();
    bus.result_ack = 1'b0;
    start          = 1'b0;
    check("ackstart_rv", bus.result_valid, 0);
    check("ackstart_idle", bus.src_ready, 0);
    vals = '{1, 2, 3, 0, 0, 0, 0, 0};
    fold(2'b00, 3, -1);
    check("next_start_result", bus.result, 6);
    ack_result();

    // Asynchronous reset mid-RUN after 2 elements
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    bus.src_ack   = 1'b1;
    bus.src_value = 8'd50;
    tick();
    bus.src_value = 8'd60;
    tick();
    bus.src_ack = 1'b0;
    check("pre_rst_count", bus.count, 2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", bus.src_ready, 0);
    check("mid_rst_req", bus.src_req, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_rv", bus.result_valid, 0);
    tick();
    reset_n = 1'b1;
    tick();
    vals = '{1, 2, 3, 0, 0, 0, 0, 0};
    fold(2'b00, 3, -1);
    check("post_rst_result", bus.result, 6);
    check("post_rst_count", bus.count, 3);
    ack_result();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/list_fold.md
LIST_FOLD -- requirements
Module: list_fold

Interface
REQ-001 Parameter WIDTH, default 8, element width of the incoming list values.
REQ-002 Parameter ACC_WIDTH, default 16, width of the accumulator, result and count; SHALL be >= WIDTH.
REQ-003 clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  begin folding one list; sampled only in IDLE.
REQ-006 op  input  2  fold operation, sampled with start: 00 sum, 01 max, 10 min, 11 count-only.
REQ-007 abort  input  1  cancel an in-progress fold.
REQ-008 src_ready  output  1  list-active strobe to the upstream enumerator; high for the whole traversal.
REQ-009 src_req  output  1  element request to upstream.
REQ-010 src_ack  input  1  element valid this cycle.
REQ-011 src_eol  input  1  qualifies src_ack; element in this cycle is the final one and is included.
REQ-012 src_value  input  WIDTH  element value, valid when src_ack=1.
REQ-013 result  output  ACC_WIDTH  fold result, valid while result_valid=1.
REQ-014 count  output  ACC_WIDTH  number of elements consumed.
REQ-015 overflow  output  1  sum overflow flag (see Configuration).
REQ-016 result_valid  output  1  result/count/overflow are valid and held.
REQ-017 result_ack  input  1  downstream consumed the result.

Function
REQ-018 FSM states: IDLE, START, RUN, DONE, all registered.
REQ-019 IDLE: on start=1, latch op, clear acc, count and overflow, and go to START; otherwise hold.
REQ-020 START: assert src_ready for one cycle with src_req=0 so upstream sees a rising ready edge and restarts its list, then go to RUN.
REQ-021 RUN: src_ready=1 and src_req=1 continuously; each cycle with src_ack=1 consumes exactly one element.
REQ-022 Element consumption: count<=count+1; sum adds src_value zero-extended to ACC_WIDTH; max/min takes the first element unconditionally (count==0), then the unsigned max/min; count-only leaves acc at 0.
REQ-023 RUN with src_ack=1 and src_eol=1: consume that element, deassert src_ready and src_req on the next edge, and go to DONE.
REQ-024 src_eol without src_ack SHALL be ignored.
REQ-025 DONE: result_valid=1; result, count and overflow held stable; src_ready=src_req=0.
REQ-026 DONE with result_ack=1: return to IDLE; result_valid falls on that edge.
REQ-027 start is ignored outside IDLE; start and result_ack in the same DONE cycle go to IDLE only, and start is not retained.
REQ-028 abort=1 in START or RUN: go to IDLE next edge, drop src_ready/src_req, no result_valid; abort wins over a simultaneous src_ack/src_eol.
REQ-029 abort is ignored in IDLE and DONE.
REQ-030 Latency: result_valid rises exactly one cycle after the cycle carrying src_ack & src_eol.
REQ-031 count wraps modulo 2^ACC_WIDTH.
REQ-032 Lists are non-empty; upstream guarantees at least one ack per traversal.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, with acc, count, result, overflow, result_valid, src_ready and src_req all 0.
REQ-034 Reset mid-RUN SHALL discard the partial fold; the first start after release begins a fresh list.

Configuration
REQ-035 Macro LIST_FOLD_SAT_EN defined: a sum that exceeds 2^ACC_WIDTH-1 SHALL clamp acc to all-ones and set overflow sticky until the next start.
REQ-036 LIST_FOLD_SAT_EN undefined: the sum wraps modulo 2^ACC_WIDTH and overflow is tied to 0; max, min and count-only are unaffected either way.

Verification
REQ-037 Sum, enumerator 3..7 (ack each cycle, eol with 7), op=00 -> result=25, count=5, result_valid one cycle after the eol ack.
REQ-038 Max and min, elements 5,9,2, op=01 then op=10 -> result=9, then result=2, count=3 both times.
REQ-039 Overflow, ACC_WIDTH=8, elements 200,100, op=00 -> with macro result=255, overflow=1; without macro result=44, overflow=0.
REQ-040 Abort asserted on the same cycle as the second element's ack -> IDLE next cycle, src_ready=0, result_valid never asserted; a following start sums a full fresh list.
REQ-041 reset_n pulsed low in RUN after 2 elements -> all outputs 0 asynchronously; next list 1..3 -> result=6.
REQ-042 result_ack and start together in DONE -> IDLE, start ignored; start on the following cycle is accepted (START reached next edge).
